array_seq_ctrl: RTL and testbench
=================================

ARRAY_SEQ_CTRL -- requirements
Module: array_seq_ctrl

Interface
REQ-001 SHALL have parameters: DW, default 8, data width; ROW_W, default 4, row-index width; COL_W, default 4, column-index width; N_ROWS, default 4, active rows; N_COLS, default 4, active columns.
REQ-002 SHALL have ports: clk in 1, single clock, all logic on rising edge; rst in 1, reset, synchronous active-high.
REQ-003 SHALL have ports: start in 1, begin a job when idle; reuse_w in 1, sampled with start, skip weight load; abort in 1, cancel job; busy out 1, job in progress; done out 1, one-cycle completion pulse.
REQ-004 SHALL have ports: w_valid in 1, w_data in DW, w_ready out 1, weight stream (valid/ready).
REQ-005 SHALL have ports: x_valid in 1, x_data in DW, x_ready out 1, activation stream (valid/ready).
REQ-006 SHALL have ports: cfg_addr out ROW_W+COL_W, {row,col}; cfg_data out DW; cfg_valid out 1, drive the tile array configuration bus.
REQ-007 SHALL have ports: x_row out ROW_W, x_out out DW, x_we out 1, row-targeted activation write; global_state out 2, array-wide phase.

Function
REQ-008 SHALL implement FSM IDLE, LOAD_W, LOAD_X, MAC, DONE; global_state encodes LOAD_W=0, LOAD_X=1, MAC=2, IDLE/DONE=3.
REQ-009 SHALL, in IDLE with start=1, go to LOAD_X if reuse_w=1 and w_loaded=1, else LOAD_W; start while not IDLE is ignored.
REQ-010 SHALL assert w_ready only in LOAD_W; each w_valid&w_ready beat registers cfg_valid=1, cfg_data=w_data, cfg_addr={row,col} on the next cycle.
REQ-011 SHALL walk weight addresses row-major from {0,0}: col increments, wraps at N_COLS-1 to 0 while row increments; after beat N_ROWS*N_COLS go to LOAD_X and set w_loaded=1.
REQ-012 SHALL assert x_ready only in LOAD_X; each x beat registers x_we=1, x_out=x_data, x_row=row counter next cycle; after N_ROWS beats go to MAC.
REQ-013 SHALL hold counters and emit no cfg_valid/x_we on cycles without handshake (stalls of any length are legal).
REQ-014 SHALL remain in MAC exactly N_ROWS+N_COLS-1 cycles, then DONE for one cycle with done=1, then IDLE.
REQ-015 SHALL assert busy in all states except IDLE; busy is registered, rising the cycle after start is accepted.
REQ-016 SHALL, on abort=1 in any non-IDLE state, go to IDLE next cycle, suppress done, clear counters, clear w_loaded if aborted in LOAD_W; abort has priority over any handshake that cycle (beat not consumed, w_ready/x_ready drop with state).
REQ-017 SHALL register all outputs; no combinational input-to-output path except w_ready/x_ready, which are state decodes only.

Reset
REQ-018 SHALL, on rst=1 at a clock edge, force state IDLE, w_loaded=0, counters 0, busy=0, done=0, w_ready=0, x_ready=0, cfg_valid=0, x_we=0, cfg_addr=0, cfg_data=0, x_row=0, x_out=0, global_state=3.
REQ-019 SHALL treat rst mid-job like abort plus w_loaded clear; rst overrides abort and start.

Structure
REQ-020 SHALL import phase encodings (S_LOAD_W, S_LOAD_X, S_MAC, S_IDLE) and FSM state constants from shared package sa_pkg, also used by tile_pe.
REQ-021 SHALL instantiate one sub-module rc_counter (row/col counter with enable, clear, wrap and last flags) for weight addressing; x-row and MAC counters inline.

Verification
REQ-022 Defaults, start, weights 1..16 streamed back-to-back -> cfg_addr 0x00,0x01..0x03,0x10..0x33 with matching data, 16 cfg_valid pulses, global_state 0 then 1.
REQ-023 x beats 3,4,5,6 -> x_we with x_row 0..3, exactly 7 MAC cycles, done high one cycle, busy low the next cycle.
REQ-024 w_valid toggled every other cycle -> 16 beats still counted, addresses contiguous, no extra cfg_valid.
REQ-025 Second job with reuse_w=1 -> no w_ready, global_state goes 3->1 directly; reuse_w=1 after reset -> full LOAD_W.
REQ-026 abort after 5 weight beats -> IDLE next cycle, no done, w_loaded=0; next start restarts at cfg_addr 0x00.
REQ-027 rst asserted during MAC -> all outputs at reset values next cycle; start during busy ignored.

Source files
------------

// File: rtl/sa_pkg.sv
// Shared encodings for the systolic-array sequencer and its tiles.
// Holds the array-wide phase codes and the sequencer FSM state type.
package sa_pkg;

    // Array-wide phase codes broadcast to every tile_pe.
    localparam logic [1:0] S_LOAD_W = 2'd0;
    localparam logic [1:0] S_LOAD_X = 2'd1;
    localparam logic [1:0] S_MAC    = 2'd2;
    localparam logic [1:0] S_IDLE   = 2'd3;

    // Sequencer FSM states.
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD_W,
        ST_LOAD_X,
        ST_MAC,
        ST_DONE
    } seq_state_e;

    // Map a sequencer state to the phase code seen by the tiles.
    // IDLE and DONE both read as S_IDLE.
    function automatic logic [1:0] phase_of(input seq_state_e st);
        logic [1:0] ph;
        case (st)
            ST_LOAD_W: ph = S_LOAD_W;
            ST_LOAD_X: ph = S_LOAD_X;
            ST_MAC:    ph = S_MAC;
            default:   ph = S_IDLE;
        endcase
        return ph;
    endfunction

endpackage

// File: rtl/rc_counter.sv
// Row-major {row,col} counter used to address the weight tiles.
// Column advances on each enable and wraps to 0 while the row advances;
// after the last cell the whole counter wraps back to {0,0}.
module rc_counter #(
    parameter int ROW_W  = 4,
    parameter int COL_W  = 4,
    parameter int N_ROWS = 4,
    parameter int N_COLS = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    output logic [ROW_W-1:0] row,
    output logic [COL_W-1:0] col,
    output logic             col_last,
    output logic             row_last
);

    localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(N_ROWS - 1);
    localparam logic [COL_W-1:0] COL_MAX = COL_W'(N_COLS - 1);

    logic [ROW_W-1:0] row_q, row_d;
    logic [COL_W-1:0] col_q, col_d;

    assign col_last = (col_q == COL_MAX);
    assign row_last = (row_q == ROW_MAX);
    assign row      = row_q;
    assign col      = col_q;

    // Next-count logic: clear wins over enable, wrap on the last column/row.
    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path leaves it unassigned and no latch is inferred.
        row_d = row_q;
        col_d = col_q;
        if (clr) begin
            row_d = '0;
            col_d = '0;
        end else if (en) begin
            if (col_last) begin
                col_d = '0;
                row_d = row_last ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end
    end

    // Counter registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments here so every flop samples pre-edge values regardless of statement order.
        if (rst) begin
            row_q <= '0;
            col_q <= '0;
        end else begin
            row_q <= row_d;
            col_q <= col_d;
        end
    end

endmodule

// File: rtl/array_seq_ctrl.sv
// Job sequencer for a systolic tile array: streams weights into the tile
// configuration bus, streams one activation per row, then holds the MAC
// phase for the array's pipeline depth and pulses done.
module array_seq_ctrl
    import sa_pkg::*;
#(
    parameter int DW     = 8,
    parameter int ROW_W  = 4,
    parameter int COL_W  = 4,
    parameter int N_ROWS = 4,
    parameter int N_COLS = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   reuse_w,
    input  logic                   abort,
    output logic                   busy,
    output logic                   done,
    input  logic                   w_valid,
    input  logic [DW-1:0]          w_data,
    output logic                   w_ready,
    input  logic                   x_valid,
    input  logic [DW-1:0]          x_data,
    output logic                   x_ready,
    output logic [ROW_W+COL_W-1:0] cfg_addr,
    output logic [DW-1:0]          cfg_data,
    output logic                   cfg_valid,
    output logic [ROW_W-1:0]       x_row,
    output logic [DW-1:0]          x_out,
    output logic                   x_we,
    output logic [1:0]             global_state
);

    // MAC phase lasts long enough for data to cross rows and columns.
    localparam int               MC_W     = ROW_W + COL_W;
    localparam logic [MC_W-1:0]  MAC_LAST = MC_W'(N_ROWS + N_COLS - 2);
    localparam logic [ROW_W-1:0] X_LAST   = ROW_W'(N_ROWS - 1);

    seq_state_e             state_q, state_d;
    logic                   w_loaded_q, w_loaded_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   cfg_valid_q, cfg_valid_d;
    logic [MC_W-1:0]        cfg_addr_q, cfg_addr_d;
    logic [DW-1:0]          cfg_data_q, cfg_data_d;
    logic                   x_we_q, x_we_d;
    logic [ROW_W-1:0]       x_row_q, x_row_d;
    logic [DW-1:0]          x_out_q, x_out_d;
    logic [1:0]             gstate_q, gstate_d;
    logic [ROW_W-1:0]       x_cnt_q, x_cnt_d;
    logic [MC_W-1:0]        mac_cnt_q, mac_cnt_d;

    logic                   abort_act;
    logic                   w_fire;
    logic                   x_fire;
    logic                   wc_clr;
    logic [ROW_W-1:0]       wc_row;
    logic [COL_W-1:0]       wc_col;
    logic                   wc_col_last;
    logic                   wc_row_last;

    // Ready is a pure state decode; abort blocks the handshake instead.
    assign w_ready   = (state_q == ST_LOAD_W);
    assign x_ready   = (state_q == ST_LOAD_X);
    assign abort_act = abort && (state_q != ST_IDLE);
    assign w_fire    = w_valid && w_ready && !abort;
    assign x_fire    = x_valid && x_ready && !abort;
    assign wc_clr    = abort_act || (state_q == ST_IDLE);

    rc_counter #(
        .ROW_W  (ROW_W),
        .COL_W  (COL_W),
        .N_ROWS (N_ROWS),
        .N_COLS (N_COLS)
    ) u_wcnt (
        .clk      (clk),
        .rst      (rst),
        .en       (w_fire),
        .clr      (wc_clr),
        .row      (wc_row),
        .col      (wc_col),
        .col_last (wc_col_last),
        .row_last (wc_row_last)
    );

    // Next-state and next-output logic; abort overrides every state action.
    always_comb begin
        state_d     = state_q;
        w_loaded_d  = w_loaded_q;
        cfg_valid_d = 1'b0;
        cfg_addr_d  = cfg_addr_q;
        cfg_data_d  = cfg_data_q;
        x_we_d      = 1'b0;
        x_row_d     = x_row_q;
        x_out_d     = x_out_q;
        x_cnt_d     = x_cnt_q;
        mac_cnt_d   = mac_cnt_q;

        if (abort_act) begin
            state_d   = ST_IDLE;
            x_cnt_d   = '0;
            mac_cnt_d = '0;
            if (state_q == ST_LOAD_W) begin
                w_loaded_d = 1'b0;
            end
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        if (reuse_w && w_loaded_q) begin
                            state_d = ST_LOAD_X;
                        end else begin
                            // Weights are about to be overwritten.
                            state_d    = ST_LOAD_W;
                            w_loaded_d = 1'b0;
                        end
                    end
                end
                ST_LOAD_W: begin
                    if (w_fire) begin
                        cfg_valid_d = 1'b1;
                        cfg_data_d  = w_data;
                        cfg_addr_d  = {wc_row, wc_col};
                        if (wc_row_last && wc_col_last) begin
                            state_d    = ST_LOAD_X;
                            w_loaded_d = 1'b1;
                        end
                    end
                end
                ST_LOAD_X: begin
                    if (x_fire) begin
                        x_we_d  = 1'b1;
                        x_out_d = x_data;
                        x_row_d = x_cnt_q;
                        if (x_cnt_q == X_LAST) begin
                            x_cnt_d = '0;
                            state_d = ST_MAC;
                        end else begin
                            x_cnt_d = x_cnt_q + 1'b1;
                        end
                    end
                end
                ST_MAC: begin
                    if (mac_cnt_q == MAC_LAST) begin
                        mac_cnt_d = '0;
                        state_d   = ST_DONE;
                    end else begin
                        mac_cnt_d = mac_cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        // Status outputs follow the state being entered, so they line up with it.
        busy_d   = (state_d != ST_IDLE);
        done_d   = (state_d == ST_DONE);
        gstate_d = phase_of(state_d);
    end

    // State and output registers; reset also clears the weight-valid flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            w_loaded_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            cfg_valid_q <= 1'b0;
            cfg_addr_q  <= '0;
            cfg_data_q  <= '0;
            x_we_q      <= 1'b0;
            x_row_q     <= '0;
            x_out_q     <= '0;
            gstate_q    <= S_IDLE;
            x_cnt_q     <= '0;
            mac_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            w_loaded_q  <= w_loaded_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            cfg_valid_q <= cfg_valid_d;
            cfg_addr_q  <= cfg_addr_d;
            cfg_data_q  <= cfg_data_d;
            x_we_q      <= x_we_d;
            x_row_q     <= x_row_d;
            x_out_q     <= x_out_d;
            gstate_q    <= gstate_d;
            x_cnt_q     <= x_cnt_d;
            mac_cnt_q   <= mac_cnt_d;
        end
    end

    assign busy         = busy_q;
    assign done         = done_q;
    assign cfg_valid    = cfg_valid_q;
    assign cfg_addr     = cfg_addr_q;
    assign cfg_data     = cfg_data_q;
    assign x_we         = x_we_q;
    assign x_row        = x_row_q;
    assign x_out        = x_out_q;
    assign global_state = gstate_q;

endmodule

// File: tb/tb_array_seq_ctrl.sv
// Directed bench for array_seq_ctrl with default parameters.
module tb_array_seq_ctrl;

    localparam int DW     = 8;
    localparam int ROW_W  = 4;
    localparam int COL_W  = 4;
    localparam int N_ROWS = 4;
    localparam int N_COLS = 4;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   start;
    logic                   reuse_w;
    logic                   abort;
    logic                   busy;
    logic                   done;
    logic                   w_valid;
    logic [DW-1:0]          w_data;
    logic                   w_ready;
    logic                   x_valid;
    logic [DW-1:0]          x_data;
    logic                   x_ready;
    logic [ROW_W+COL_W-1:0] cfg_addr;
    logic [DW-1:0]          cfg_data;
    logic                   cfg_valid;
    logic [ROW_W-1:0]       x_row;
    logic [DW-1:0]          x_out;
    logic                   x_we;
    logic [1:0]             global_state;

    int n_checks = 0;
    int n_fail   = 0;

    // Observed events, gathered on the falling edge.
    logic [15:0] cfg_log[$];
    logic [11:0] x_log[$];
    int mac_cycles     = 0;
    int done_cnt       = 0;
    int w_ready_cycles = 0;

    int base_cfg;
    int base_x;
    int base_mac;
    int base_done;
    int base_w;

    always #5 clk = ~clk;

    array_seq_ctrl #(
        .DW     (DW),
        .ROW_W  (ROW_W),
        .COL_W  (COL_W),
        .N_ROWS (N_ROWS),
        .N_COLS (N_COLS)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .reuse_w      (reuse_w),
        .abort        (abort),
        .busy         (busy),
        .done         (done),
        .w_valid      (w_valid),
        .w_data       (w_data),
        .w_ready      (w_ready),
        .x_valid      (x_valid),
        .x_data       (x_data),
        .x_ready      (x_ready),
        .cfg_addr     (cfg_addr),
        .cfg_data     (cfg_data),
        .cfg_valid    (cfg_valid),
        .x_row        (x_row),
        .x_out        (x_out),
        .x_we         (x_we),
        .global_state (global_state)
    );

    // Event monitor.
    always @(negedge clk) begin
        if (cfg_valid === 1'b1) cfg_log.push_back({cfg_addr, cfg_data});
        if (x_we === 1'b1) x_log.push_back({x_row, x_out});
        if (global_state === 2'd2) mac_cycles++;
        if (done === 1'b1) done_cnt++;
        if (w_ready === 1'b1) w_ready_cycles++;
    end

    // Watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic start_job(input logic r);
        start   = 1'b1;
        reuse_w = r;
        tick();
        start   = 1'b0;
        reuse_w = 1'b0;
    endtask

    task automatic send_w(input logic [DW-1:0] d);
        int t = 0;
        w_valid = 1'b1;
        w_data  = d;
        while (w_ready !== 1'b1 && t < 20) begin
            tick();
            t++;
        end
        if (t >= 20) check("w_ready_wait", 32'(w_ready), 32'd1);
        tick();
        w_valid = 1'b0;
    endtask

    task automatic send_x(input logic [DW-1:0] d);
        int t = 0;
        x_valid = 1'b1;
        x_data  = d;
        while (x_ready !== 1'b1 && t < 20) begin
            tick();
            t++;
        end
        if (t >= 20) check("x_ready_wait", 32'(x_ready), 32'd1);
        tick();
        x_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int t = 0;
        while (done !== 1'b1 && t < 100) begin
            tick();
            t++;
        end
        check(tag, 32'(done), 32'd1);
    endtask

    // Weight beat i lands at row-major address {i/N_COLS, i%N_COLS}.
    task automatic check_cfg(input string tag, input int base, input int n, input int d0);
        for (int i = 0; i < n; i++) begin
            check(tag, 32'(cfg_log[base + i]),
                  32'((((i / N_COLS) * 16 + (i % N_COLS)) << 8) | ((d0 + i) & 8'hFF)));
        end
    endtask

    task automatic check_x(input string tag, input int base, input int d0, input int step);
        for (int i = 0; i < N_ROWS; i++) begin
            check(tag, 32'(x_log[base + i]), 32'((i << 8) | ((d0 + i * step) & 8'hFF)));
        end
    endtask

    task automatic check_reset_outputs(input string pfx);
        check({pfx, "_busy"},      32'(busy),         32'd0);
        check({pfx, "_done"},      32'(done),         32'd0);
        check({pfx, "_w_ready"},   32'(w_ready),      32'd0);
        check({pfx, "_x_ready"},   32'(x_ready),      32'd0);
        check({pfx, "_cfg_valid"}, 32'(cfg_valid),    32'd0);
        check({pfx, "_x_we"},      32'(x_we),         32'd0);
        check({pfx, "_cfg_addr"},  32'(cfg_addr),     32'd0);
        check({pfx, "_cfg_data"},  32'(cfg_data),     32'd0);
        check({pfx, "_x_row"},     32'(x_row),        32'd0);
        check({pfx, "_x_out"},     32'(x_out),        32'd0);
        check({pfx, "_gstate"},    32'(global_state), 32'd3);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; reuse_w = 1'b0; abort = 1'b0;
        w_valid = 1'b0; w_data = '0; x_valid = 1'b0; x_data = '0;
        tick();
        tick();
        check_reset_outputs("rst0");
        rst = 1'b0;
        tick();

        // Job 1: full weight load 1..16 back-to-back, x = 3,4,5,6.
        base_cfg = cfg_log.size(); base_x = x_log.size(); base_mac = mac_cycles;
        start_job(1'b0);
        check("j1_busy", 32'(busy), 32'd1);
        check("j1_gs_loadw", 32'(global_state), 32'd0);
        check("j1_w_ready", 32'(w_ready), 32'd1);
        for (int i = 0; i < 16; i++) send_w(DW'(i + 1));
        check("j1_gs_loadx", 32'(global_state), 32'd1);
        check("j1_cfg_count", 32'(cfg_log.size() - base_cfg), 32'd16);
        check_cfg("j1_cfg", base_cfg, 16, 1);
        for (int i = 0; i < 4; i++) send_x(DW'(3 + i));
        check("j1_x_count", 32'(x_log.size() - base_x), 32'd4);
        check_x("j1_x", base_x, 3, 1);
        wait_done("j1_done");
        check("j1_mac_cycles", 32'(mac_cycles - base_mac), 32'd7);
        tick();
        check("j1_done_pulse", 32'(done), 32'd0);
        check("j1_busy_low", 32'(busy), 32'd0);
        check("j1_gs_idle", 32'(global_state), 32'd3);

        // Job 2: reuse weights, x beats with a stall between each.
        base_cfg = cfg_log.size(); base_x = x_log.size(); base_mac = mac_cycles;
        base_w = w_ready_cycles;
        start_job(1'b1);
        check("j2_gs_loadx", 32'(global_state), 32'd1);
        check("j2_w_ready", 32'(w_ready), 32'd0);
        for (int i = 0; i < 4; i++) begin
            send_x(DW'(8'h40 + i));
            tick();
        end
        wait_done("j2_done");
        check("j2_mac_cycles", 32'(mac_cycles - base_mac), 32'd7);
        check("j2_x_count", 32'(x_log.size() - base_x), 32'd4);
        check_x("j2_x", base_x, 8'h40, 1);
        check("j2_no_w_ready", 32'(w_ready_cycles - base_w), 32'd0);
        check("j2_no_cfg", 32'(cfg_log.size() - base_cfg), 32'd0);
        tick();

        // Job 3: w_valid every other cycle, plus a start while busy.
        base_cfg = cfg_log.size(); base_x = x_log.size();
        start_job(1'b0);
        for (int i = 0; i < 16; i++) begin
            send_w(DW'(8'hA0 + i));
            if (i == 2) begin
                start   = 1'b1;
                reuse_w = 1'b1;
            end
            tick();
            if (i == 2) check("j3_start_ignored", 32'(global_state), 32'd0);
            start   = 1'b0;
            reuse_w = 1'b0;
        end
        check("j3_gs_loadx", 32'(global_state), 32'd1);
        check("j3_cfg_count", 32'(cfg_log.size() - base_cfg), 32'd16);
        check_cfg("j3_cfg", base_cfg, 16, 8'hA0);
        for (int i = 0; i < 4; i++) send_x(DW'(8'h10 + 2 * i));
        check_x("j3_x", base_x, 8'h10, 2);
        wait_done("j3_done");
        tick();

        // Abort after 5 weight beats; a beat offered with abort is dropped.
        base_cfg = cfg_log.size(); base_done = done_cnt;
        start_job(1'b0);
        for (int i = 0; i < 5; i++) send_w(DW'(8'h50 + i));
        w_valid = 1'b1; w_data = 8'hEE; abort = 1'b1;
        tick();
        abort = 1'b0; w_valid = 1'b0;
        check("ab_gs_idle", 32'(global_state), 32'd3);
        check("ab_busy", 32'(busy), 32'd0);
        check("ab_cfg_valid", 32'(cfg_valid), 32'd0);
        check("ab_cfg_count", 32'(cfg_log.size() - base_cfg), 32'd5);
        tick();
        tick();
        check("ab_no_done", 32'(done_cnt - base_done), 32'd0);

        // reuse_w is refused because the aborted load cleared w_loaded.
        start_job(1'b1);
        check("ab_gs_reload", 32'(global_state), 32'd0);
        send_w(8'h77);
        check("ab_addr0", 32'(cfg_addr), 32'h00);
        check("ab_data0", 32'(cfg_data), 32'h77);
        for (int i = 1; i < 16; i++) send_w(DW'(8'h80 + i));
        for (int i = 0; i < 4; i++) send_x(DW'(8'hC0 + i));
        check("mac_gs", 32'(global_state), 32'd2);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("mac_start_ignored", 32'(global_state), 32'd2);
        check("mac_busy", 32'(busy), 32'd1);

        // Reset mid-MAC, with start and abort also high.
        rst = 1'b1; start = 1'b1; abort = 1'b1;
        tick();
        rst = 1'b0; start = 1'b0; abort = 1'b0;
        check_reset_outputs("rst_mac");
        tick();
        check("rst_no_done", 32'(done_cnt - base_done), 32'd0);

        // After reset, reuse_w must still run a full weight load.
        start_job(1'b1);
        check("rst_reuse_gs", 32'(global_state), 32'd0);
        check("rst_reuse_w_ready", 32'(w_ready), 32'd1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("final_gs_idle", 32'(global_state), 32'd3);
        check("total_done", 32'(done_cnt), 32'd3);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
